// File: rtl/serial_frame_deserializer.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Define DESER_PARITY_EN to add the parity bit and the parity_err output.
module serial_frame_deserializer #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
`ifdef DESER_PARITY_EN
  output logic              parity_err,
`endif
  input  logic              ovr_clr
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              ferr_q;
  logic              ovr_q;
  logic              commit_d;
  logic              accept_d;
`ifdef DESER_PARITY_EN
  logic              par_q;
  logic              perr_q;
  logic              par_ok_d;
`endif

  // A frame is committable only on a 0 stop bit (and matching parity when enabled).
  always_comb begin
    commit_d = 1'b0;
`ifdef DESER_PARITY_EN
    par_ok_d = ~(^{shift_q, par_q});
    commit_d = (state_q == S_STOP) && !serial_in && par_ok_d;
`else
    commit_d = (state_q == S_STOP) && !serial_in;
`endif
    accept_d = valid_q && data_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DESER_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (serial_in) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_DATA: begin
          // Right shift: after DATA_W bits the first received bit sits at bit 0.
          shift_q <= {serial_in, shift_q[DATA_W-1:1]};
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) begin
`ifdef DESER_PARITY_EN
            state_q <= S_PARITY;
`else
            state_q <= S_STOP;
`endif
          end
        end
`ifdef DESER_PARITY_EN
        S_PARITY: begin
          par_q   <= serial_in;
          state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ferr_q  <= serial_in;
`ifdef DESER_PARITY_EN
          perr_q  <= !serial_in && !par_ok_d;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Same-edge accept and commit keeps data_valid high with no bubble.
      if (commit_d && (!valid_q || data_ready)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (accept_d) begin
        valid_q <= 1'b0;
      end

      if (commit_d && valid_q && !data_ready) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
`ifdef DESER_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer: directed frames plus randomized traffic
// checked every cycle against a frame-level holding-register model.
module tb_serial_frame_deserializer;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready;
  logic          busy;
  logic          frame_err;
  logic          overrun;
  logic          ovr_clr;
`ifdef DESER_PARITY_EN
  logic          parity_err;
`endif

  serial_frame_deserializer #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef DESER_PARITY_EN
    .parity_err (parity_err),
`endif
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_data;
  logic          m_valid, m_busy, m_ferr, m_perr, m_ovr;

  localparam int EV_IDLE = 0, EV_BIT = 1, EV_GOOD = 2, EV_FERR = 3, EV_PERR = 4;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 0; m_busy = 0; m_ferr = 0; m_perr = 0; m_ovr = 0;
  endtask

  task automatic check_all();
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef DESER_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  // One clock: drive the line bit, then apply the frame-level event to the model.
  task automatic cycle(input logic b, input int ev, input logic [DW-1:0] w);
    logic set_o;
    serial_in = b;
    @(posedge clk);
    set_o  = 1'b0;
    m_busy = (ev == EV_BIT);
    m_ferr = (ev == EV_FERR);
    m_perr = (ev == EV_PERR);
    if (ev == EV_GOOD) begin
      if (!m_valid || data_ready) begin
        m_data  = w;
        m_valid = 1'b1;
      end else begin
        set_o = 1'b1;
      end
    end else if (m_valid && data_ready) begin
      m_valid = 1'b0;
    end
    if (set_o) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    #1;
    check_all();
  endtask

  // hs: 0 keep handshake inputs, 1 randomize per cycle, 2 ready only on the stop bit.
  task automatic set_hs(input int hs, input bit is_stop);
    if (hs == 1) begin
      data_ready = 1'($urandom_range(0, 1));
      ovr_clr    = ($urandom_range(0, 9) == 0);
    end else if (hs == 2) begin
      data_ready = is_stop;
      ovr_clr    = 1'b0;
    end
  endtask

  task automatic frame(input logic [DW-1:0] w, input bit bad_stop, input bit bad_par, input int hs);
    int ev;
    set_hs(hs, 0);
    cycle(1'b1, EV_BIT, w);
    for (int i = 0; i < DW; i++) begin
      set_hs(hs, 0);
      cycle(w[i], EV_BIT, w);
    end
`ifdef DESER_PARITY_EN
    set_hs(hs, 0);
    cycle((^w) ^ bad_par, EV_BIT, w);
`endif
    ev = bad_stop ? EV_FERR : (bad_par ? EV_PERR : EV_GOOD);
    set_hs(hs, 1);
    cycle(bad_stop, ev, w);
  endtask

  task automatic idle(input int n, input int hs);
    for (int i = 0; i < n; i++) begin
      set_hs(hs, 0);
      cycle(1'b0, EV_IDLE, '0);
    end
  endtask

  initial begin
    rst = 1'b0; serial_in = 1'b0; data_ready = 1'b0; ovr_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Basic frame, held until accepted
    data_ready = 1'b0;
    frame(4'hD, 0, 0, 0);
    chk("t1_word", 32'(data_out), 32'hD);
    data_ready = 1'b1;
    idle(1, 0);
    data_ready = 1'b0;

    // Framing error then a good frame
    frame(4'h0, 1, 0, 0);
    idle(1, 0);
    frame(4'hA, 0, 0, 0);
    chk("t2_word", 32'(data_out), 32'hA);
    data_ready = 1'b1;
    idle(1, 0);

    // Overrun, clear, then simultaneous accept at the commit edge
    data_ready = 1'b0;
    frame(4'hD, 0, 0, 0);
    frame(4'h3, 0, 0, 0);
    chk("t3_hold", 32'(data_out), 32'hD);
    chk("t3_ovr", 32'(overrun), 32'h1);
    ovr_clr = 1'b1;
    idle(1, 0);
    ovr_clr = 1'b0;
    data_ready = 1'b1;
    idle(1, 0);
    data_ready = 1'b0;
    frame(4'hD, 0, 0, 0);
    frame(4'h3, 0, 0, 2);
    chk("t3_swap", 32'(data_out), 32'h3);
    chk("t3_nobubble", 32'(data_valid), 32'h1);
    idle(1, 0);

    // Asynchronous reset mid-frame
    data_ready = 1'b0;
    frame(4'h5, 0, 0, 0);
    cycle(1'b1, EV_BIT, '0);
    cycle(1'b1, EV_BIT, '0);
    cycle(1'b0, EV_BIT, '0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_valid", 32'(data_valid), 32'h0);
    chk("t4_data", 32'(data_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    frame(4'hE, 0, 0, 0);
    chk("t4_word", 32'(data_out), 32'hE);
    data_ready = 1'b1;
    idle(1, 0);

    // Idle immunity and back-to-back frames with an always-ready consumer
    idle(20, 0);
    frame(4'hF, 0, 0, 0);
    frame(4'h0, 0, 0, 0);
    idle(2, 0);

`ifdef DESER_PARITY_EN
    data_ready = 1'b0;
    frame(4'hD, 0, 0, 0);
    chk("t6_word", 32'(data_out), 32'hD);
    data_ready = 1'b1;
    idle(1, 0);
    data_ready = 1'b0;
    frame(4'hD, 0, 1, 0);
    idle(1, 0);
`endif

    // Randomized traffic
    for (int f = 0; f < 150; f++) begin
      logic [DW-1:0] w;
      bit bs, bp;
      w  = DW'($urandom);
      bs = ($urandom_range(0, 7) == 0);
      bp = 1'b0;
`ifdef DESER_PARITY_EN
      bp = ($urandom_range(0, 7) == 0);
`endif
      frame(w, bs, bp, 1);
      idle($urandom_range(0, 3), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
